// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Shared constants and helpers for the mul_div request scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam int FLAG_W = 5;

    localparam int FLG_IO = 0;
    localparam int FLG_DZ = 1;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 3;
    localparam int FLG_I  = 4;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // Response entry is packed as {id, R, flags}.
    function automatic int rsp_entry_w(input int id_w, input int n);
        return id_w + 2 * n + FLAG_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_rsp_fifo.sv
// ============================================================================
// Module   : muldiv_rsp_fifo
// Brief    : Synchronous FIFO with occupancy count; head is zero when empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_sched.sv
// ============================================================================
// Module   : muldiv_sched
// Brief    : Round-robin scheduler sharing one mul_div unit among requesters,
//            with tag pipeline, credit-based issue and a response FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_sched
    import muldiv_pkg::*;
#(
    parameter int N          = 10,
    parameter int NREQ       = 2,
    parameter int LAT        = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*N-1:0]         req_a,
    input  logic [NREQ*N-1:0]         req_b,
    input  logic [NREQ-1:0]           req_sel,
    output logic [N-1:0]              md_a,
    output logic [N-1:0]              md_b,
    output logic                      md_sel,
    output logic                      md_en,
    input  logic [2*N-1:0]            md_R,
    input  logic [FLAG_W-1:0]         md_flags,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [2*N-1:0]            rsp_R,
    output logic [FLAG_W-1:0]         rsp_flags,
    output logic                      busy
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = rsp_entry_w(ID_W, N);

    logic [ID_W-1:0]          rr_ptr_q,   rr_ptr_d;
    logic [CW-1:0]            inflight_q, inflight_d;
    logic [N-1:0]             md_a_q,     md_a_d;
    logic [N-1:0]             md_b_q,     md_b_d;
    logic                     md_sel_q,   md_sel_d;
    logic                     md_en_q,    md_en_d;
    logic [LAT:0]             tag_v_q,    tag_v_d;
    logic [LAT:0][ID_W-1:0]   tag_id_q,   tag_id_d;

    logic                     found_hi, found_lo;
    logic [ID_W-1:0]          win_hi, win_lo, winner;
    logic [CW:0]              credit_sum;
    logic                     credit_ok;
    logic                     accept;
    logic [N-1:0]             win_a, win_b;
    logic                     win_sel;
    logic                     push;
    logic                     fifo_empty;
    logic [CW-1:0]            fifo_count;
    logic [ENT_W-1:0]         fifo_head;

    // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                found_lo = 1'b1;
                win_lo   = ID_W'(i);
                if (ID_W'(i) >= rr_ptr_q) begin
                    found_hi = 1'b1;
                    win_hi   = ID_W'(i);
                end
            end
        end
        winner = found_hi ? win_hi : win_lo;
    end

    always_comb begin
        win_a   = '0;
        win_b   = '0;
        win_sel = OP_MUL;
        for (int i = 0; i < NREQ; i++) begin
            if (ID_W'(i) == winner) begin
                win_a   = req_a[i*N +: N];
                win_b   = req_b[i*N +: N];
                win_sel = req_sel[i];
            end
        end
    end

    // Registered counts only, so a pop frees its credit one cycle later.
    assign credit_sum = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign credit_ok  = credit_sum < (CW+1)'(FIFO_DEPTH);
    assign accept     = found_lo && credit_ok && !arst;
    assign req_ready  = accept ? (NREQ'(1) << winner) : '0;
    assign push       = tag_v_q[LAT];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (winner == ID_W'(NREQ - 1)) ? '0 : winner + 1'b1;
        end
        md_a_d   = accept ? win_a   : md_a_q;
        md_b_d   = accept ? win_b   : md_b_q;
        md_sel_d = accept ? win_sel : md_sel_q;
        md_en_d  = accept;

        tag_v_d     = '0;
        tag_id_d    = '0;
        tag_v_d[0]  = accept;
        tag_id_d[0] = winner;
        for (int k = 1; k <= LAT; k++) begin
            tag_v_d[k]  = tag_v_q[k-1];
            tag_id_d[k] = tag_id_q[k-1];
        end

        inflight_d = inflight_q;
        case ({accept, push})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rr_ptr_q   <= '0;
            inflight_q <= '0;
            md_a_q     <= '0;
            md_b_q     <= '0;
            md_sel_q   <= 1'b0;
            md_en_q    <= 1'b0;
            tag_v_q    <= '0;
            tag_id_q   <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            inflight_q <= inflight_d;
            md_a_q     <= md_a_d;
            md_b_q     <= md_b_d;
            md_sel_q   <= md_sel_d;
            md_en_q    <= md_en_d;
            tag_v_q    <= tag_v_d;
            tag_id_q   <= tag_id_d;
        end
    end

    assign md_a   = md_a_q;
    assign md_b   = md_b_q;
    assign md_sel = md_sel_q;
    assign md_en  = md_en_q;

    muldiv_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .arst      (arst),
        .push      (push),
        .push_data ({tag_id_q[LAT], md_R, md_flags}),
        .pop       (rsp_valid && rsp_ready),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rsp_valid                    = !fifo_empty;
    assign {rsp_id, rsp_R, rsp_flags}   = fifo_head;
    assign busy                         = (inflight_q != '0) || !fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sched.sv
// ============================================================================
// Module   : tb_muldiv_sched
// Brief    : Directed, table-driven self-checking bench for muldiv_sched.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_sched;
    import muldiv_pkg::*;

    localparam int N          = 10;
    localparam int NREQ       = 2;
    localparam int LAT        = 1;
    localparam int FIFO_DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 arst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*N-1:0]    req_a;
    logic [NREQ*N-1:0]    req_b;
    logic [NREQ-1:0]      req_sel;
    logic [N-1:0]         md_a;
    logic [N-1:0]         md_b;
    logic                 md_sel;
    logic                 md_en;
    logic [2*N-1:0]       md_R;
    logic [FLAG_W-1:0]    md_flags;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [0:0]           rsp_id;
    logic [2*N-1:0]       rsp_R;
    logic [FLAG_W-1:0]    rsp_flags;
    logic                 busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        int              id;
        logic [2*N-1:0]  r;
        logic [4:0]      f;
        int              cyc;
    } rec_t;

    typedef struct {
        int              req;
        logic [N-1:0]    a;
        logic [N-1:0]    b;
        logic            sel;
        logic [2*N-1:0]  r;
        logic [4:0]      f;
    } vec_t;

    rec_t rsp_q[$];
    int   acc_q[$];
    vec_t vecs[6];

    muldiv_sched #(
        .N          (N),
        .NREQ       (NREQ),
        .LAT        (LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .md_a      (md_a),
        .md_b      (md_b),
        .md_sel    (md_sel),
        .md_en     (md_en),
        .md_R      (md_R),
        .md_flags  (md_flags),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_R     (rsp_R),
        .rsp_flags (rsp_flags),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural mul_div: mul -> a*b (uf if zero); div -> {a/b, a%b}, div by zero -> all ones with dz (io too for 0/0).
    function automatic logic [2*N+4:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input logic sel);
        logic [2*N-1:0] r;
        logic [4:0]     f;
        f = 5'b0;
        if (sel == 1'b0) begin
            r = {{N{1'b0}}, a} * {{N{1'b0}}, b};
            if (r == '0) f[FLG_UF] = 1'b1;
        end else if (b == '0) begin
            r = '1;
            f[FLG_DZ] = 1'b1;
            if (a == '0) f[FLG_IO] = 1'b1;
        end else begin
            r = {a / b, a % b};
        end
        return {r, f};
    endfunction

    // Garbage on md_R/md_flags whenever no result is due.
    always @(posedge clk) begin
        if (md_en) {md_R, md_flags} <= model(md_a, md_b, md_sel);
        else begin
            md_R     <= (2*N)'($urandom);
            md_flags <= 5'($urandom);
        end
    end

    always begin
        @(negedge clk);
        #1;
        if (rsp_valid && rsp_ready) rsp_q.push_back('{int'(rsp_id), rsp_R, rsp_flags, cyc});
        for (int i = 0; i < NREQ; i++) if (req_valid[i] && req_ready[i]) acc_q.push_back(i);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (!busy) break;
        end
        chk("idle", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int k;

        vecs[0] = '{0, 10'h155, 10'h0AA, 1'b0, 20'h0E272, 5'b00000};
        vecs[1] = '{1, 10'h064, 10'h007, 1'b1, 20'h03802, 5'b00000};
        vecs[2] = '{1, 10'h155, 10'h000, 1'b1, 20'hFFFFF, 5'b00010};
        vecs[3] = '{0, 10'h000, 10'h000, 1'b1, 20'hFFFFF, 5'b00011};
        vecs[4] = '{0, 10'h000, 10'h3FF, 1'b0, 20'h00000, 5'b01000};
        vecs[5] = '{1, 10'h3FF, 10'h3FF, 1'b0, 20'hFF801, 5'b00000};

        arst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        req_valid = 2'b11;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_md_en",     64'(md_en),     64'd0);
        chk("rst_md_a",      64'(md_a),      64'd0);
        chk("rst_md_b",      64'(md_b),      64'd0);
        chk("rst_md_sel",    64'(md_sel),    64'd0);
        chk("rst_rsp_id",    64'(rsp_id),    64'd0);
        chk("rst_rsp_R",     64'(rsp_R),     64'd0);
        chk("rst_rsp_flags", 64'(rsp_flags), 64'd0);
        req_valid = '0;
        @(negedge clk);
        arst = 1'b0;

        // Fairness: both requesters valid for 8 cycles from rr_ptr = 0.
        @(negedge clk);
        rsp_ready = 1'b1;
        req_a = {10'd2, 10'd1}; req_b = {10'd5, 10'd4}; req_sel = 2'b00;
        acc_q.delete(); rsp_q.delete();
        req_valid = 2'b11;
        repeat (8) @(negedge clk);
        req_valid = '0;
        wait_idle();
        chk("fair_acc_count", 64'(acc_q.size()), 64'd8);
        chk("fair_rsp_count", 64'(rsp_q.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < acc_q.size()) chk("fair_grant", 64'(acc_q[i]), 64'(i % 2));
            if (i < rsp_q.size()) begin
                chk("fair_rsp_id", 64'(rsp_q[i].id), 64'(i % 2));
                chk("fair_no_bubble", 64'(rsp_q[i].cyc - rsp_q[0].cyc), 64'(i));
            end
        end

        // Table-driven single requests with exact timing.
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            rsp_ready = 1'b1;
            req_a[vecs[v].req*N +: N] = vecs[v].a;
            req_b[vecs[v].req*N +: N] = vecs[v].b;
            req_sel[vecs[v].req]      = vecs[v].sel;
            req_valid = NREQ'(1) << vecs[v].req;
            #1;
            for (int w = 0; w < 10; w++) begin
                if (req_ready[vecs[v].req]) break;
                @(negedge clk);
                #1;
            end
            chk("vec_grant", 64'(req_ready), 64'(NREQ'(1) << vecs[v].req));
            @(negedge clk);
            req_valid = '0;
            #1;
            chk("vec_md_en",  64'(md_en),  64'd1);
            chk("vec_md_a",   64'(md_a),   64'(vecs[v].a));
            chk("vec_md_b",   64'(md_b),   64'(vecs[v].b));
            chk("vec_md_sel", 64'(md_sel), 64'(vecs[v].sel));
            @(negedge clk);
            #1;
            chk("vec_md_en_pulse",   64'(md_en),     64'd0);
            chk("vec_rsp_not_early", 64'(rsp_valid), 64'd0);
            @(negedge clk);
            #1;
            chk("vec_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("vec_rsp_id",    64'(rsp_id),    64'(vecs[v].req));
            chk("vec_rsp_R",     64'(rsp_R),     64'(vecs[v].r));
            chk("vec_rsp_flags", 64'(rsp_flags), 64'(vecs[v].f));
            @(negedge clk);
            #1;
            chk("vec_rsp_one_cycle", 64'(rsp_valid), 64'd0);
        end
        wait_idle();

        // Backpressure: credit limits outstanding work to FIFO_DEPTH.
        @(negedge clk);
        rsp_ready = 1'b0;
        req_a = {10'd0, 10'd1}; req_b = {10'd0, 10'd1}; req_sel = 2'b00;
        acc_q.delete();
        req_valid = 2'b01;
        repeat (12) @(negedge clk);
        #1;
        chk("bp_acc_count", 64'(acc_q.size()), 64'd4);
        chk("bp_blocked",   64'(req_ready),    64'd0);
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        chk("bp_no_early_accept", 64'(req_ready), 64'd0);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("bp_accept_after_pop", 64'(req_ready), 64'd1);
        @(negedge clk);
        #1;
        chk("bp_blocked_again", 64'(req_ready),    64'd0);
        chk("bp_acc_total",     64'(acc_q.size()), 64'd5);
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle();

        // Wrap-around: 20 back-to-back requests from requester 0.
        acc_q.delete(); rsp_q.delete();
        k = 0;
        for (int c = 0; c < 200 && k < 20; c++) begin
            @(negedge clk);
            req_valid = 2'b01;
            req_a[N-1:0] = N'(k + 1);
            req_b[N-1:0] = N'(3);
            req_sel[0]   = 1'b0;
            #1;
            if (req_ready[0]) k++;
        end
        @(negedge clk);
        req_valid = '0;
        wait_idle();
        chk("wrap_rsp_count", 64'(rsp_q.size()), 64'd20);
        for (int j = 0; j < rsp_q.size() && j < 20; j++) begin
            chk("wrap_rsp_id",    64'(rsp_q[j].id), 64'd0);
            chk("wrap_rsp_R",     64'(rsp_q[j].r),  64'((j + 1) * 3));
            chk("wrap_rsp_flags", 64'(rsp_q[j].f),  64'd0);
        end
        if (rsp_q.size() >= 20) chk("wrap_back_to_back", 64'(rsp_q[19].cyc - rsp_q[0].cyc), 64'd19);

        // Reset with two operations in flight and one buffered.
        @(negedge clk);
        rsp_ready = 1'b0;
        req_a[N-1:0] = N'(5); req_b[N-1:0] = N'(6);
        req_valid = 2'b01;
        repeat (3) @(negedge clk);
        req_valid = '0;
        #1;
        chk("mid_buffered", 64'(rsp_valid), 64'd1);
        chk("mid_busy",     64'(busy),      64'd1);
        arst = 1'b1;
        req_valid = 2'b01;
        #1;
        chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_busy",      64'(busy),      64'd0);
        chk("mid_rst_md_en",     64'(md_en),     64'd0);
        @(negedge clk);
        arst = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        rsp_q.delete();
        #1;
        chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("post_rst_busy",      64'(busy),      64'd0);
        repeat (10) @(negedge clk);
        #1;
        chk("post_rst_no_rsp", 64'(rsp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
